// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter with a fixed MSB-first mode and a
// round-robin mode, presented on a valid/ready output stage.

// One lane of the rotator. Rotated bit j maps to req[(j + base) mod N], so the
// highest set rotated bit is the first hit in the search order base-1, base-2, ...
module prio_rot_lane #(
  parameter int N = 16,
  parameter int W = $clog2(N),
  parameter int J = 0
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         hit
);
  localparam logic [W:0] JW = (W+1)'(J);
  localparam logic [W:0] NW = (W+1)'(N);

  logic [W:0] sum;
  logic [W:0] src;

  always_comb begin
    sum = JW + {1'b0, base};
    src = (sum >= NW) ? sum - NW : sum;
    hit = req[src[W-1:0]];
  end
endmodule

module prio_encoder_arb #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic         out_multi
);
  localparam logic [W:0] NW = (W+1)'(N);

  typedef struct packed {
    logic [W-1:0] idx;
    logic [N-1:0] grant;
    logic         multi;
  } res_t;

  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [N-1:0] rot;
  logic [W-1:0] win_rot;
  logic [W:0]   win_sum;
  logic [W-1:0] win_idx;
  logic         any_req;
  logic         cap;
  res_t         nxt;
  res_t         res;
  // Single-stage output pipe; index 0 is the capture strobe, index 1 is out_valid.
  logic [1:0]   vld_pipe;

  // Fixed mode is round-robin with the pointer forced to 0.
  assign base = mode ? ptr : '0;

  for (genvar j = 0; j < N; j++) begin : g_lane
    prio_rot_lane #(.N(N), .W(W), .J(j)) u_lane (
      .req  (req),
      .base (base),
      .hit  (rot[j])
    );
  end

  always_comb begin
    win_rot = '0;
    for (int j = 0; j < N; j++)
      if (rot[j]) win_rot = W'(j);
    win_sum = {1'b0, win_rot} + {1'b0, base};
    win_idx = (win_sum >= NW) ? W'(win_sum - NW) : W'(win_sum);
  end

  assign any_req     = |req;
  assign cap         = en & any_req & (~vld_pipe[1] | out_ready);
  assign vld_pipe[0] = cap;

  always_comb begin
    nxt.idx   = win_idx;
    nxt.grant = N'(1) << win_idx;
    nxt.multi = |(req & (req - N'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      res         <= '0;
      ptr         <= '0;
    end else if (cap) begin
      vld_pipe[1] <= 1'b1;
      res         <= nxt;
      if (mode) ptr <= win_idx;
    end else if (out_ready) begin
      // Drain: payload stays at its last value.
      vld_pipe[1] <= 1'b0;
    end
  end

  assign out_valid = vld_pipe[1];
  assign out_idx   = res.idx;
  assign out_grant = res.grant;
  assign out_multi = res.multi;
endmodule
